// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the core top level.
// Optional checksum support is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_boot_loader_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERROR
  } loader_state_e;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_rx_state(input loader_state_e s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CHK);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Packs little-endian stream bytes into 32-bit instruction words and flags each
// completed word with a one-cycle word_valid pulse.
module imem_word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               byte_en_i,
  input  logic [7:0]         byte_i,
  output logic               last_byte_o,
  output logic               word_valid_o,
  output logic [INSTR_W-1:0] word_o
);

  logic [1:0]         byte_idx_q;
  logic [INSTR_W-1:0] shift_q;
  logic               word_valid_q;

  assign last_byte_o = byte_en_i && (byte_idx_q == 2'd3);

  // Shifting right puts the first byte in bits [7:0] once all four have arrived;
  // the completed word then holds for the whole word_valid cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx_q   <= '0;
      shift_q      <= '0;
      word_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      word_valid_q <= last_byte_o;
      if (clear_i) begin
        byte_idx_q <= '0;
      end else if (byte_en_i) begin
        shift_q    <= {byte_i, shift_q[INSTR_W-1:8]};
        byte_idx_q <= byte_idx_q + 2'd1;
      end
    end
  end

  assign word_valid_o = word_valid_q;
  assign word_o       = shift_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads instruction memory from a length-prefixed byte stream while holding the
// core in reset. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LEN_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_rst_n,
  output logic [LEN_W-1:0]   words_loaded
);

  localparam int unsigned     NUM_WORDS   = 2 ** ADDR_W;
  localparam logic [LEN_W:0]  NUM_WORDS_W = NUM_WORDS[LEN_W:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e   FINISH_S    = S_CHK;
`else
  localparam loader_state_e   FINISH_S    = S_DONE;
`endif

  loader_state_e     state_q, state_d;
  logic [LEN_W-1:0]  len_q, words_loaded_q, len_full;
  logic [ADDR_W-1:0] waddr_q;
  logic              rx_ready_q, busy_q, done_q, error_q, cpu_rst_n_q;
  logic              accept, start_load, data_byte, last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  assign accept     = rx_valid && rx_ready_q;
  assign start_load = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
  assign data_byte  = accept && (state_q == S_DATA);
  assign len_full   = LEN_W'({rx_data, len_q[7:0]});

  imem_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_load),
    .byte_en_i    (data_byte),
    .byte_i       (rx_data),
    .last_byte_o  (last_byte),
    .word_valid_o (imem_we),
    .word_o       (imem_wdata)
  );

  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len_full == '0)                        state_d = FINISH_S;
          else if ({1'b0, len_full} > NUM_WORDS_W)   state_d = S_ERROR;
          else                                       state_d = S_DATA;
        end
      end
      // Leaves DATA on the same edge that launches the final write.
      S_DATA: if (last_byte && (words_loaded_q + LEN_W'(1)) == len_q) state_d = FINISH_S;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      words_loaded_q <= '0;
      waddr_q        <= '0;
      rx_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      cpu_rst_n_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q          <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= is_rx_state(state_d);
      busy_q      <= is_rx_state(state_d);
      done_q      <= (state_d == S_DONE);
      error_q     <= (state_d == S_ERROR);
      // Released only after a full cycle in DONE, so never alongside the last write.
      cpu_rst_n_q <= (state_q == S_DONE) && (state_d == S_DONE);

      if (accept && state_q == S_LEN_LO) len_q[7:0] <= rx_data;
      if (accept && state_q == S_LEN_HI) len_q      <= len_full;

      if (start_load) begin
        words_loaded_q <= '0;
      end else if (last_byte) begin
        words_loaded_q <= words_loaded_q + LEN_W'(1);
        waddr_q        <= words_loaded_q[ADDR_W-1:0];
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (start_load)     chk_q <= '0;
      else if (data_byte) chk_q <= chk_q ^ rx_data;
`endif
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_waddr   = waddr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign words_loaded = words_loaded_q;

endmodule
